// File: rtl/pcm_capture_pkg.sv
// Shared definitions for the PCM capture path: FSM state encoding, the
// sample-rate clamp, frame sizing and the per-state byte/sequence helpers.
package pcm_capture_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ST_L_LO = 3'd1,
        ST_L_HI = 3'd2,
        ST_R_LO = 3'd3,
        ST_R_HI = 3'd4
    } state_t;

    // Largest accumulator step; a step of 128 captures on every strobe.
    localparam logic [7:0] RATE_MAX = 8'd128;

    // Bytes per frame for the given channel mode and sample width.
    function automatic logic [2:0] frame_size(input logic stereo, input logic b16);
        case ({stereo, b16})
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // First byte of a frame: 16-bit frames start with the low byte,
    // 8-bit frames only carry the high byte.
    function automatic state_t first_state(input logic b16);
        return b16 ? ST_L_LO : ST_L_HI;
    endfunction

    // Little-endian, left channel first.
    function automatic state_t next_state(input state_t s, input logic stereo, input logic b16);
        case (s)
            ST_L_LO: return ST_L_HI;
            ST_L_HI: return stereo ? (b16 ? ST_R_LO : ST_R_HI) : IDLE;
            ST_R_LO: return ST_R_HI;
            default: return IDLE;
        endcase
    endfunction

    // Byte written while in state s, picked from the latched channel words.
    function automatic logic [7:0] state_byte(input state_t s, input logic [15:0] l,
                                              input logic [15:0] r);
        // NOTE: every path returns a value (default arm included) so any
        // combinational use of this helper can never infer a latch.
        case (s)
            ST_L_LO: return l[7:0];
            ST_L_HI: return l[15:8];
            ST_R_LO: return r[7:0];
            ST_R_HI: return r[15:8];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Single-clock byte FIFO with a registered read port. Exposes the free
// count for frame admission plus empty / almost-full (>= 3/4) / full flags.
// Synchronous active-low reset; flush empties it without touching rd_data.
module capture_fifo
    import pcm_capture_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic [DEPTH_LOG2:0]   free,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   AF_C    = (DEPTH_LOG2 + 1)'((3 * DEPTH) / 4);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_wr;
    logic                  do_rd;

    // Flush wins over both ports; reads of an empty FIFO are ignored.
    assign do_wr       = wr_en && !full && !flush;
    assign do_rd       = rd_en && !empty && !flush;
    assign empty       = (count == '0);
    assign full        = (count == DEPTH_C);
    assign almost_full = (count >= AF_C);
    assign free        = DEPTH_C - count;

    // Storage array write port.
    // NOTE: the storage array has no reset; only pointers and count define
    // what is valid, which keeps the array mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy count and the registered read data.
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= 8'h00;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                rd_data <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pcm_capture.sv
// PCM capture path: decimates the stereo ADC stream on the shared audio
// timebase, packs each frame little-endian (left first) and stores it in
// the capture FIFO, which the host drains one byte at a time.
// Build option PCM_CAPTURE_ROUND_EN: when defined, 8-bit samples are
// rounded (+0x80, saturating at 0x7F) instead of truncated.
module pcm_capture
    import pcm_capture_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        next_sample,
    input  logic [7:0]  sample_rate,
    input  logic        mode_stereo,
    input  logic        mode_16bit,
    input  logic [15:0] left_in,
    input  logic [15:0] right_in,
    input  logic        fifo_reset,
    input  logic        fifo_read,
    output logic [7:0]  fifo_rddata,
    output logic        fifo_empty,
    output logic        fifo_almost_full,
    output logic        fifo_full,
    output logic        overflow,
    output logic        busy
);

    // Reduce a 16-bit sample to the single byte kept in 8-bit mode.
    function automatic logic [7:0] to_byte(input logic [15:0] s);
`ifdef PCM_CAPTURE_ROUND_EN
        logic [15:0] t;
        t = s + 16'h0080;
        // A positive sample that wraps negative saturates to full scale.
        if (!s[15] && t[15]) begin
            return 8'h7F;
        end
        return t[15:8];
`else
        return s[15:8];
`endif
    endfunction

    logic [7:0]          acc;
    logic                acc7_r;
    logic                strobe_d;
    logic                new_sample;
    logic [7:0]          rate_c;

    logic [16:0]         sum17;
    logic [15:0]         mono;
    logic [15:0]         left_sel;
    logic [15:0]         ch_l_in;
    logic [15:0]         ch_r_in;

    state_t              state;
    state_t              nxt_state;
    state_t              first_st;
    logic [15:0]         ch_l;
    logic [15:0]         ch_r;
    logic                stereo_r;
    logic                b16_r;
    logic                wr_en;
    logic [7:0]          wr_data;
    logic [DEPTH_LOG2:0] free;

    assign rate_c     = (sample_rate > RATE_MAX) ? RATE_MAX : sample_rate;
    assign new_sample = strobe_d && (acc7_r != acc[7]);

    // Mono is the 17-bit sum shifted right once; bits [16:1] are exactly
    // the arithmetic shift truncated back to 16 bits.
    assign sum17    = {left_in[15], left_in} + {right_in[15], right_in};
    assign mono     = sum17[16:1];
    assign left_sel = mode_stereo ? left_in : mono;
    // 8-bit frames only ever write the high byte of each channel word.
    assign ch_l_in  = mode_16bit ? left_sel : {to_byte(left_sel), 8'h00};
    assign ch_r_in  = mode_16bit ? right_in : {to_byte(right_in), 8'h00};

    assign first_st  = first_state(mode_16bit);
    assign nxt_state = next_state(state, stereo_r, b16_r);

    // Rate accumulator: a capture fires when bit 7 flips across a strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= 8'h00;
            acc7_r   <= 1'b0;
            strobe_d <= 1'b0;
        end else begin
            strobe_d <= next_sample;
            if (next_sample) begin
                acc    <= acc + rate_c;
                acc7_r <= acc[7];
            end
        end
    end

    // Frame FSM: admits whole frames only, then emits one byte per cycle.
    // 'state' names the byte being written this cycle; busy/wr_en/wr_data
    // are registered alongside it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            wr_en    <= 1'b0;
            wr_data  <= 8'h00;
            overflow <= 1'b0;
            ch_l     <= 16'h0000;
            ch_r     <= 16'h0000;
            stereo_r <= 1'b0;
            b16_r    <= 1'b0;
        end else if (fifo_reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            wr_en    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (new_sample) begin
                        if (free >= (DEPTH_LOG2 + 1)'(frame_size(mode_stereo, mode_16bit))) begin
                            ch_l     <= ch_l_in;
                            ch_r     <= ch_r_in;
                            stereo_r <= mode_stereo;
                            b16_r    <= mode_16bit;
                            state    <= first_st;
                            busy     <= 1'b1;
                            wr_en    <= 1'b1;
                            wr_data  <= state_byte(first_st, ch_l_in, ch_r_in);
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (new_sample) begin
                        overflow <= 1'b1;
                    end
                    state   <= nxt_state;
                    busy    <= (nxt_state != IDLE);
                    wr_en   <= (nxt_state != IDLE);
                    wr_data <= state_byte(nxt_state, ch_l, ch_r);
                end
            endcase
        end
    end

    capture_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (fifo_reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (fifo_read),
        .rd_data     (fifo_rddata),
        .free        (free),
        .empty       (fifo_empty),
        .almost_full (fifo_almost_full),
        .full        (fifo_full)
    );

endmodule

// File: tb/tb_pcm_capture.sv
// Testbench for pcm_capture with a 16-byte FIFO. Directed table of frames,
// hand-written corner sequences, then randomized frames against a queue
// model of the capture path.
module tb_pcm_capture;

    localparam int DL2   = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        next_sample = 1'b0;
    logic [7:0]  sample_rate = 8'd0;
    logic        mode_stereo = 1'b0;
    logic        mode_16bit = 1'b0;
    logic [15:0] left_in = 16'h0000;
    logic [15:0] right_in = 16'h0000;
    logic        fifo_reset = 1'b0;
    logic        fifo_read = 1'b0;
    logic [7:0]  fifo_rddata;
    logic        fifo_empty;
    logic        fifo_almost_full;
    logic        fifo_full;
    logic        overflow;
    logic        busy;

    always #5 clk = ~clk;

    pcm_capture #(.DEPTH_LOG2(DL2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .next_sample      (next_sample),
        .sample_rate      (sample_rate),
        .mode_stereo      (mode_stereo),
        .mode_16bit       (mode_16bit),
        .left_in          (left_in),
        .right_in         (right_in),
        .fifo_reset       (fifo_reset),
        .fifo_read        (fifo_read),
        .fifo_rddata      (fifo_rddata),
        .fifo_empty       (fifo_empty),
        .fifo_almost_full (fifo_almost_full),
        .fifo_full        (fifo_full),
        .overflow         (overflow),
        .busy             (busy)
    );

    typedef struct {
        logic        stereo;
        logic        b16;
        logic [15:0] l;
        logic [15:0] r;
        int          n;
        logic [31:0] bytes;   // byte k of the frame at [8k+7:8k]
    } tv_t;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] exp_q[$];
    int         acc_m = 0;
    logic       ovf_m = 1'b0;
    logic [7:0] last_rd = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // 8-bit reduction of a signed sample value.
    function automatic logic [7:0] to_byte8(input int v);
`ifdef PCM_CAPTURE_ROUND_EN
        int t;
        t = v + 128;
        if (t > 32767) return 8'h7F;
        return 8'((t >>> 8) & 255);
`else
        return 8'((v >>> 8) & 255);
`endif
    endfunction

    // Model of one timebase strobe; returns bytes admitted (0 if none).
    function automatic int model_strobe();
        int         rc, li, ri, lv;
        bit         cap;
        logic [7:0] fb[$];
        rc  = (sample_rate > 8'd128) ? 128 : int'(sample_rate);
        cap = ((acc_m + rc) / 128) != (acc_m / 128);
        acc_m = (acc_m + rc) % 256;
        if (!cap) return 0;
        li = int'($signed(left_in));
        ri = int'($signed(right_in));
        lv = mode_stereo ? li : ((li + ri) >>> 1);
        if (mode_16bit) begin
            fb.push_back(8'(lv & 255));
            fb.push_back(8'((lv >> 8) & 255));
            if (mode_stereo) begin
                fb.push_back(8'(ri & 255));
                fb.push_back(8'((ri >> 8) & 255));
            end
        end else begin
            fb.push_back(to_byte8(lv));
            if (mode_stereo) fb.push_back(to_byte8(ri));
        end
        if (fb.size() > DEPTH - exp_q.size()) begin
            ovf_m = 1'b1;
            return 0;
        end
        foreach (fb[k]) exp_q.push_back(fb[k]);
        return fb.size();
    endfunction

    // One strobe, then watch busy for 7 cycles (index 0 = two cycles after strobe).
    task automatic strobe(output int bcnt, output int bfirst, output int admitted);
        @(posedge clk); #1;
        next_sample = 1'b1;
        admitted = model_strobe();
        @(posedge clk); #1;
        next_sample = 1'b0;
        bcnt = 0;
        bfirst = -1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            if (busy) begin
                bcnt++;
                if (bfirst < 0) bfirst = i;
            end
        end
    endtask

    task automatic read_byte(output logic [7:0] d);
        @(posedge clk); #1;
        fifo_read = 1'b1;
        @(posedge clk); #1;
        fifo_read = 1'b0;
        d = fifo_rddata;
    endtask

    // Pop one byte and compare with the model (hold value when empty).
    task automatic pop_check(input string name);
        logic [7:0] d, e;
        read_byte(d);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            last_rd = e;
        end else begin
            e = last_rd;
        end
        check(name, {24'h0, d}, {24'h0, e});
    endtask

    task automatic drain(input string name, output int n);
        n = 0;
        for (int i = 0; i < DEPTH + 2 && !fifo_empty; i++) begin
            pop_check($sformatf("%s_byte%0d", name, i));
            n++;
        end
        check({name, "_model_left"}, exp_q.size(), 0);
    endtask

    task automatic check_flags(input string name);
        check({name, "_overflow"}, {31'h0, overflow}, {31'h0, ovf_m});
        check({name, "_empty"}, {31'h0, fifo_empty}, {31'h0, exp_q.size() == 0});
        check({name, "_full"}, {31'h0, fifo_full}, {31'h0, exp_q.size() == DEPTH});
        check({name, "_afull"}, {31'h0, fifo_almost_full}, {31'h0, exp_q.size() >= 12});
    endtask

    task automatic pulse_fifo_reset();
        @(posedge clk); #1;
        fifo_reset = 1'b1;
        @(posedge clk); #1;
        fifo_reset = 1'b0;
        exp_q.delete();
        ovf_m = 1'b0;
    endtask

    task automatic set_frame(input logic st, input logic b16, input logic [15:0] l,
                             input logic [15:0] r);
        mode_stereo = st;
        mode_16bit  = b16;
        left_in     = l;
        right_in    = r;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tv_t        tv[10];
        int         bc, bf, adm, n;
        logic [7:0] d;

        tv[0] = '{1'b1, 1'b1, 16'h1234, 16'hABCD, 4, 32'hABCD_1234};
        tv[1] = '{1'b0, 1'b0, 16'h4000, 16'h2000, 1, 32'h0000_0030};
        tv[2] = '{1'b0, 1'b0, 16'h8000, 16'h8000, 1, 32'h0000_0080};
`ifdef PCM_CAPTURE_ROUND_EN
        tv[3] = '{1'b0, 1'b0, 16'h12C0, 16'h12C0, 1, 32'h0000_0013};
`else
        tv[3] = '{1'b0, 1'b0, 16'h12C0, 16'h12C0, 1, 32'h0000_0012};
`endif
        tv[4] = '{1'b0, 1'b0, 16'h7FC0, 16'h7FC0, 1, 32'h0000_007F};
        tv[5] = '{1'b1, 1'b0, 16'h1234, 16'hAB40, 2, 32'h0000_AB12};
        tv[6] = '{1'b0, 1'b1, 16'h0100, 16'h0300, 2, 32'h0000_0200};
        tv[7] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 2, 32'h0000_FFFF};
        tv[8] = '{1'b1, 1'b1, 16'h8000, 16'h7FFF, 4, 32'h7FFF_8000};
        tv[9] = '{1'b0, 1'b0, 16'hF000, 16'hE000, 1, 32'h0000_00E8};

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_rddata", {24'h0, fifo_rddata}, 0);
        check_flags("rst");
        rst_n = 1'b1;

        // Directed frames at full rate.
        sample_rate = 8'd128;
        for (int i = 0; i < 10; i++) begin
            set_frame(tv[i].stereo, tv[i].b16, tv[i].l, tv[i].r);
            strobe(bc, bf, adm);
            check($sformatf("tv%0d_busy_cycles", i), bc, tv[i].n);
            check($sformatf("tv%0d_busy_start", i), bf, 0);
            for (int j = 0; j < tv[i].n; j++) begin
                read_byte(d);
                check($sformatf("tv%0d_byte%0d", i, j), {24'h0, d}, {24'h0, tv[i].bytes[8*j +: 8]});
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                last_rd = tv[i].bytes[8*j +: 8];
            end
            check($sformatf("tv%0d_empty_after", i), {31'h0, fifo_empty}, 1);
        end

        // Rate 64: 8 strobes give 4 frames of 16-bit mono.
        sample_rate = 8'd64;
        set_frame(1'b0, 1'b1, 16'h0246, 16'h1357);
        for (int i = 0; i < 8; i++) strobe(bc, bf, adm);
        drain("rate64", n);
        check("rate64_bytes", n, 8);

        // Rate 0 never captures.
        sample_rate = 8'd0;
        for (int i = 0; i < 8; i++) strobe(bc, bf, adm);
        check("rate0_empty", {31'h0, fifo_empty}, 1);

        // Fill to one free byte, then an oversized frame is dropped.
        sample_rate = 8'd128;
        pulse_fifo_reset();
        for (int i = 0; i < 7; i++) begin
            set_frame(1'b0, 1'b1, 16'(i * 977), 16'(i * 311 + 5));
            strobe(bc, bf, adm);
        end
        set_frame(1'b0, 1'b0, 16'h5500, 16'h3300);
        strobe(bc, bf, adm);
        check_flags("fill15");
        set_frame(1'b0, 1'b1, 16'h1111, 16'h2222);
        strobe(bc, bf, adm);
        check("drop_busy", bc, 0);
        check("drop_overflow", {31'h0, overflow}, 1);
        check_flags("drop");
        set_frame(1'b0, 1'b0, 16'h6600, 16'h2200);
        strobe(bc, bf, adm);
        check_flags("fill16");
        pulse_fifo_reset();
        check("freset_overflow", {31'h0, overflow}, 0);
        check("freset_empty", {31'h0, fifo_empty}, 1);
        check_flags("freset");

        // fifo_reset while in ST_L_HI of a 16-bit stereo frame.
        set_frame(1'b1, 1'b1, 16'h1111, 16'h2222);
        @(posedge clk); #1;
        next_sample = 1'b1;
        adm = model_strobe();
        @(posedge clk); #1;
        next_sample = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midreset_busy_before", {31'h0, busy}, 1);
        fifo_reset = 1'b1;
        @(posedge clk); #1;
        fifo_reset = 1'b0;
        exp_q.delete();
        ovf_m = 1'b0;
        check("midreset_busy", {31'h0, busy}, 0);
        check("midreset_empty", {31'h0, fifo_empty}, 1);
        repeat (5) @(posedge clk);
        #1;
        check("midreset_empty_later", {31'h0, fifo_empty}, 1);
        check_flags("midreset");

        // Full FIFO plus overflow, partial drain, then rst_n mid-frame.
        set_frame(1'b1, 1'b1, 16'h1A5A, 16'h2B6B);
        for (int i = 0; i < 5; i++) strobe(bc, bf, adm);
        check_flags("full_ovf");
        for (int i = 0; i < 4; i++) pop_check($sformatf("pre_rst_pop%0d", i));
        @(posedge clk); #1;
        next_sample = 1'b1;
        adm = model_strobe();
        @(posedge clk); #1;
        next_sample = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstmid_busy_before", {31'h0, busy}, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        ovf_m = 1'b0;
        acc_m = 0;
        last_rd = 8'h00;
        check("rstmid_busy", {31'h0, busy}, 0);
        check("rstmid_rddata", {24'h0, fifo_rddata}, 0);
        check_flags("rstmid");

        // Randomized frames against the model.
        for (int it = 0; it < 150; it++) begin
            set_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      16'($urandom), 16'($urandom));
            sample_rate = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd128;
            strobe(bc, bf, adm);
            check($sformatf("rand%0d_busy", it), bc, adm);
            check_flags($sformatf("rand%0d", it));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 6)) pop_check($sformatf("rand%0d_pop", it));
            end
            if ($urandom_range(0, 24) == 0) pulse_fifo_reset();
        end
        drain("final", n);
        check_flags("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
